apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 103 ++++++++++
 tb/tb_apb_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: takes one command at a time over a valid/ready port, runs a
// single SETUP/ACCESS transfer with a PREADY wait timeout, returns one response.
module apb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [DATA_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLAVEERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       unaligned;
  logic       timeout_hit;

  assign accept      = cmd_valid && (state == IDLE);
  assign unaligned   = (cmd_addr[1:0] != 2'b00);
  // Fires on the TIMEOUT_CYCLES-th consecutive PREADY-low ACCESS cycle.
  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  assign cmd_ready = (state == IDLE);
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = unaligned ? RESP : SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // Unaligned commands never reach the bus, so the APB request lines keep
      // the previous transfer's values.
      if (accept && !unaligned) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_wdata;
      end

      if (accept)
        wait_cnt <= '0;
      else if ((state == ACCESS) && !PREADY)
        wait_cnt <= wait_cnt + 8'd1;

      if (accept && unaligned) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b0;
      end else if ((state == ACCESS) && PREADY) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLAVEERR;
        rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: bench-side APB completer, expected responses queued at
// command issue and compared when the response appears.
module tb_apb_master;

  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK, PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [DW-1:0] cmd_addr, cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [DW-1:0] PADDR, PWDATA, PRDATA;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLAVEERR;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
    int            lat;
  } exp_t;

  typedef struct {
    logic          got;
    logic          addr_ok;
    logic          stable;
    logic          busy;
    logic          ready_after;
    int            lat;
    int            psel;
    int            pen;
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } obs_t;

  exp_t exp_q[$];

  apb_master #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLAVEERR(PSLAVEERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Issues one command, plays the APB completer, then holds the response for
  // 'hold' cycles before handshaking. Only gathers observations.
  task automatic drive_txn(input logic wr, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                           input int low, input logic [DW-1:0] rd, input logic serr,
                           input int hold, output obs_t o);
    int cyc, acc;
    o = '{got: 1'b0, addr_ok: 1'b1, stable: 1'b1, busy: 1'b1, ready_after: 1'b0,
          lat: 0, psel: 0, pen: 0, rdata: '0, err: 1'b0, to: 1'b0};
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    tick();
    cyc = 1; acc = 0;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
    while (cyc < 64 && !o.got) begin
      if (rsp_valid) begin
        o.got = 1'b1; o.lat = cyc;
        o.rdata = rsp_rdata; o.err = rsp_err; o.to = rsp_timeout;
      end else begin
        if (PSEL) begin
          o.psel++;
          if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata) o.addr_ok = 1'b0;
        end
        if (PENABLE) o.pen++;
        if (PSEL && PENABLE) begin
          if (acc < low) begin
            PREADY = 1'b0; PRDATA = ~rd; PSLAVEERR = 1'b1;
          end else begin
            PREADY = 1'b1; PRDATA = rd; PSLAVEERR = serr;
          end
          acc++;
        end else begin
          PREADY = 1'($urandom); PRDATA = $urandom; PSLAVEERR = 1'($urandom);
        end
        tick();
        cyc++;
      end
    end
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_addr = $urandom & 32'hFFFF_FFFC; rsp_ready = 1'b0;
      tick();
      if (!rsp_valid || rsp_rdata !== o.rdata || rsp_err !== o.err || rsp_timeout !== o.to)
        o.stable = 1'b0;
      if (cmd_ready !== 1'b0 || PSEL !== 1'b0) o.busy = 1'b0;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    o.ready_after = cmd_ready;
  endtask

  task automatic test_reset();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); end
    checks++; if ({PSEL, PENABLE, PWRITE, rsp_valid} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctrl: got %b exp 0000", {PSEL, PENABLE, PWRITE, rsp_valid}); end
    checks++; if (PADDR !== '0 || PWDATA !== '0) begin errors++;
      $display("FAIL reset_bus: got %h/%h exp 0/0", PADDR, PWDATA); end
    checks++; if (rsp_rdata !== '0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin errors++;
      $display("FAIL reset_rsp: got %h/%b/%b exp 0/0/0", rsp_rdata, rsp_err, rsp_timeout); end
  endtask

  task automatic test_write();
    obs_t o; exp_t e;
    exp_q.push_back('{rdata: '0, err: 1'b0, to: 1'b0, lat: 3});
    drive_txn(1'b1, 32'h10, 32'hA5A5_0001, 0, 32'hDEAD_BEEF, 1'b0, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.got !== 1'b1 || o.lat != e.lat) begin errors++; $display("FAIL write_latency: got %0d exp %0d", o.lat, e.lat); end
    checks++; if (o.psel != 2 || o.pen != 1) begin errors++; $display("FAIL write_pulses: got psel %0d pen %0d exp 2 1", o.psel, o.pen); end
    checks++; if (o.addr_ok !== 1'b1) begin errors++; $display("FAIL write_bus: got addr_ok %b exp 1", o.addr_ok); end
    checks++; if (o.err !== e.err || o.to !== e.to || o.rdata !== e.rdata) begin errors++;
      $display("FAIL write_rsp: got %h/%b/%b exp %h/%b/%b", o.rdata, o.err, o.to, e.rdata, e.err, e.to); end
    checks++; if (o.ready_after !== 1'b1) begin errors++; $display("FAIL write_ready_n4: got %b exp 1", o.ready_after); end
  endtask

  task automatic test_wait_read();
    obs_t o; exp_t e;
    exp_q.push_back('{rdata: 32'h0000_00FF, err: 1'b0, to: 1'b0, lat: 6});
    drive_txn(1'b0, 32'h04, 32'h1111_2222, 3, 32'h0000_00FF, 1'b0, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.pen != 4 || o.psel != 5) begin errors++; $display("FAIL wait_access_len: got pen %0d psel %0d exp 4 5", o.pen, o.psel); end
    checks++; if (o.addr_ok !== 1'b1) begin errors++; $display("FAIL wait_paddr_stable: got %b exp 1", o.addr_ok); end
    checks++; if (o.lat != e.lat || o.rdata !== e.rdata || o.err !== e.err || o.to !== e.to) begin errors++;
      $display("FAIL wait_rsp: got lat %0d %h/%b/%b exp lat %0d %h/%b/%b", o.lat, o.rdata, o.err, o.to, e.lat, e.rdata, e.err, e.to); end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    exp_q.push_back('{rdata: '0, err: 1'b1, to: 1'b1, lat: TO + 2});
    drive_txn(1'b0, 32'h0C, 32'h0, 1000, 32'h5555_AAAA, 1'b0, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.pen != TO) begin errors++; $display("FAIL timeout_penable: got %0d exp %0d", o.pen, TO); end
    checks++; if (o.lat != e.lat || o.rdata !== e.rdata || o.err !== e.err || o.to !== e.to) begin errors++;
      $display("FAIL timeout_rsp: got lat %0d %h/%b/%b exp lat %0d %h/%b/%b", o.lat, o.rdata, o.err, o.to, e.lat, e.rdata, e.err, e.to); end
  endtask

  task automatic test_slverr();
    obs_t o; exp_t e;
    exp_q.push_back('{rdata: '0, err: 1'b1, to: 1'b0, lat: 3});
    drive_txn(1'b1, 32'h40, 32'hCAFE_0040, 0, 32'h0, 1'b1, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.lat != e.lat || o.err !== e.err || o.to !== e.to || o.rdata !== e.rdata) begin errors++;
      $display("FAIL slverr_rsp: got lat %0d %h/%b/%b exp lat %0d %h/%b/%b", o.lat, o.rdata, o.err, o.to, e.lat, e.rdata, e.err, e.to); end
    // PSLAVEERR is driven high on every wait cycle here and must be ignored.
    exp_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, to: 1'b0, lat: 5});
    drive_txn(1'b0, 32'h44, 32'hCAFE_0040, 2, 32'h0BAD_F00D, 1'b0, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.lat != e.lat || o.err !== e.err || o.rdata !== e.rdata) begin errors++;
      $display("FAIL wait_err_ignored: got lat %0d %h/%b exp lat %0d %h/%b", o.lat, o.rdata, o.err, e.lat, e.rdata, e.err); end
  endtask

  task automatic test_unaligned();
    obs_t o; exp_t e;
    exp_q.push_back('{rdata: '0, err: 1'b1, to: 1'b0, lat: 1});
    drive_txn(1'b1, 32'h03, 32'h7777_7777, 0, 32'h0, 1'b0, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.psel != 0) begin errors++; $display("FAIL unaligned_psel: got %0d cycles exp 0", o.psel); end
    checks++; if (o.lat != e.lat || o.err !== e.err || o.to !== e.to || o.rdata !== e.rdata) begin errors++;
      $display("FAIL unaligned_rsp: got lat %0d %h/%b/%b exp lat %0d %h/%b/%b", o.lat, o.rdata, o.err, o.to, e.lat, e.rdata, e.err, e.to); end
    checks++; if (PADDR !== 32'h44 || PWDATA !== 32'hCAFE_0040 || PWRITE !== 1'b0) begin errors++;
      $display("FAIL unaligned_bus_hold: got %h/%h/%b exp 44/cafe0040/0", PADDR, PWDATA, PWRITE); end
  endtask

  task automatic test_backpressure();
    obs_t o; exp_t e;
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0, to: 1'b0, lat: 3});
    drive_txn(1'b0, 32'h08, 32'h0, 0, 32'h1234_5678, 1'b0, 5, o);
    e = exp_q.pop_front();
    checks++; if (o.rdata !== e.rdata || o.lat != e.lat) begin errors++; $display("FAIL bp_rsp: got %h lat %0d exp %h lat %0d", o.rdata, o.lat, e.rdata, e.lat); end
    checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b exp 1", o.stable); end
    checks++; if (o.busy !== 1'b1) begin errors++; $display("FAIL bp_cmd_ignored: got %b exp 1", o.busy); end
    checks++; if (o.ready_after !== 1'b1 || PSEL !== 1'b0) begin errors++;
      $display("FAIL bp_return_idle: got ready %b psel %b exp 1 0", o.ready_after, PSEL); end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    logic wr; logic [DW-1:0] addr, wd, rd; int low;
    for (int i = 0; i < 6; i++) begin
      wr = 1'($urandom); addr = $urandom & 32'h0000_FFFC; wd = $urandom; rd = $urandom;
      low = $urandom_range(0, 3);
      exp_q.push_back('{rdata: wr ? '0 : rd, err: 1'b0, to: 1'b0, lat: 3 + low});
      drive_txn(wr, addr, wd, low, rd, 1'b0, 0, o);
      e = exp_q.pop_front();
      checks++; if (o.got !== 1'b1 || o.lat != e.lat || o.rdata !== e.rdata || o.err !== e.err || o.to !== e.to || o.addr_ok !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: got lat %0d %h/%b/%b bus %b exp lat %0d %h/%b/%b bus 1",
                 i, o.lat, o.rdata, o.err, o.to, o.addr_ok, e.lat, e.rdata, e.err, e.to);
      end
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = 32'h0;
    tick();
    cmd_valid = 1'b0; PREADY = 1'b0;
    tick();
    tick();
    checks++; if (PENABLE !== 1'b1) begin errors++; $display("FAIL rstmid_in_access: got %b exp 1", PENABLE); end
    #2 PRESETn = 1'b0;
    #1;
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin errors++;
      $display("FAIL rstmid_async_drop: got %b%b exp 00", PSEL, PENABLE); end
    PREADY = 1'b1;
    tick();
    tick();
    PRESETn = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL rstmid_after_release: got ready %b valid %b exp 1 0", cmd_ready, rsp_valid); end
    checks++; if (PADDR !== '0 || rsp_err !== 1'b0) begin errors++;
      $display("FAIL rstmid_cleared: got %h/%b exp 0/0", PADDR, rsp_err); end
  endtask

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLAVEERR = 1'b0;
    tick();
    tick();
    PRESETn = 1'b1;
    tick();
    test_reset();
    test_write();
    test_wait_read();
    test_timeout();
    test_slverr();
    test_unaligned();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
